// File: rtl/pipeline_seq_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: opcodes, PCSel codes, FSM states.
package pipeline_seq_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_STOP  = 6'd63;
  localparam logic [5:0] FN_JR    = 6'd8;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_JMP = 2'd2;
  localparam logic [1:0] PCSEL_JR  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

  // JR is an R-type with func 8
  function automatic logic is_jr(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn == FN_JR);
  endfunction

endpackage

// File: rtl/pipeline_seq_ctrl_load_use.sv
// Load-use hazard detect: LW in EX writing a register the ID instruction reads.
module load_use_detect (
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       stall
);

  // r0 is never a real dependency
  assign stall = ex_memread && (ex_rt != 5'd0) &&
                 ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

endmodule

// File: rtl/pipeline_seq_ctrl.sv
// Pipeline sequencer: hazard stall, branch/jump flush, PC mux steering,
// STOP drain/halt, and cycle/stall performance counters.
module pipeline_seq_ctrl
  import pipeline_seq_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [5:0]       ID_Opcode,
  input  logic [5:0]       ID_Func,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_BrTaken,
  output logic             PC_EN,
  output logic             IFID_EN,
  output logic             IFID_FLUSH,
  output logic             IDEX_FLUSH,
  output logic [1:0]       PCSel,
  output logic             Halted,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  seq_state_e    state, state_nxt;
  logic [DW-1:0] drain_cnt;
  logic          drain_load;
  logic          cyc_inc, stall_inc;
  logic          lu_stall;
  logic          id_jump;

  load_use_detect u_lu (
    .ex_memread (EX_MemRead),
    .ex_rt      (EX_Rt),
    .id_rs      (ID_Rs),
    .id_rt      (ID_Rt),
    .id_uses_rs (ID_UsesRs),
    .id_uses_rt (ID_UsesRt),
    .stall      (lu_stall)
  );

  assign id_jump = (ID_Opcode == OP_J) || (ID_Opcode == OP_JAL) || is_jr(ID_Opcode, ID_Func);

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Next state and outputs; event priority in RUN is branch > load-use > jump > STOP
  always_comb begin
    state_nxt  = state;
    PC_EN      = 1'b1;
    IFID_EN    = 1'b1;
    IFID_FLUSH = 1'b0;
    IDEX_FLUSH = 1'b0;
    PCSel      = PCSEL_SEQ;
    Halted     = 1'b0;
    drain_load = 1'b0;
    cyc_inc    = 1'b0;
    stall_inc  = 1'b0;
    if (RESET) begin
      state_nxt  = ST_RUN;
      PC_EN      = 1'b0;
      IFID_EN    = 1'b0;
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          cyc_inc = 1'b1;
          if (EX_BrTaken) begin
            PCSel      = PCSEL_BR;
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
          end else if (lu_stall) begin
            PC_EN      = 1'b0;
            IFID_EN    = 1'b0;
            IDEX_FLUSH = 1'b1;
            stall_inc  = 1'b1;
          end else if (id_jump) begin
            PCSel      = (ID_Opcode == OP_RTYPE) ? PCSEL_JR : PCSEL_JMP;
            IFID_FLUSH = 1'b1;
          end else if (ID_Opcode == OP_STOP) begin
            PC_EN      = 1'b0;
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
            drain_load = 1'b1;
            state_nxt  = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          cyc_inc    = 1'b1;
          PC_EN      = 1'b0;
          IFID_FLUSH = 1'b1;
          IDEX_FLUSH = 1'b1;
          if (drain_cnt == '0) state_nxt = ST_HALT;
        end
        ST_HALT: begin
          PC_EN      = 1'b0;
          IFID_EN    = 1'b0;
          IFID_FLUSH = 1'b1;
          IDEX_FLUSH = 1'b1;
          Halted     = 1'b1;
        end
        default: begin
          state_nxt  = ST_RUN;
          PC_EN      = 1'b0;
          IFID_EN    = 1'b0;
          IFID_FLUSH = 1'b1;
          IDEX_FLUSH = 1'b1;
        end
      endcase
    end
  end

  // Drain countdown: loaded when STOP leaves ID, counts to 0 in DRAIN
  always_ff @(posedge CLK) begin
    if (RESET)                                    drain_cnt <= '0;
    else if (drain_load)                          drain_cnt <= DW'(DRAIN_CYCLES - 1);
    else if (state == ST_DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
  end

  // Saturating perf counters
  always_ff @(posedge CLK) begin
    if (RESET) begin
      CycleCnt <= '0;
      StallCnt <= '0;
    end else begin
      if (cyc_inc && !(&CycleCnt))   CycleCnt <= CycleCnt + CNT_W'(1);
      if (stall_inc && !(&StallCnt)) StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// Bench for pipeline_seq_ctrl: directed scenarios then random stimulus,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_pipeline_seq_ctrl;

  localparam int DRAIN = 4;
  localparam int CW    = 8;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [5:0]    ID_Opcode, ID_Func;
  logic [4:0]    ID_Rs, ID_Rt, EX_Rt;
  logic          ID_UsesRs, ID_UsesRt, EX_MemRead, EX_BrTaken;
  logic          PC_EN, IFID_EN, IFID_FLUSH, IDEX_FLUSH, Halted;
  logic [1:0]    PCSel;
  logic [CW-1:0] CycleCnt, StallCnt;

  pipeline_seq_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_Opcode(ID_Opcode), .ID_Func(ID_Func), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_BrTaken(EX_BrTaken),
    .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IFID_FLUSH(IFID_FLUSH), .IDEX_FLUSH(IDEX_FLUSH),
    .PCSel(PCSel), .Halted(Halted), .CycleCnt(CycleCnt), .StallCnt(StallCnt)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: halted flag, cycles left in drain (-1 = running), counters
  bit          m_halt;
  int          m_left;
  int unsigned m_cyc, m_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    RESET = 0; ID_Opcode = 6'd0; ID_Func = 6'd32; ID_Rs = 5'd0; ID_Rt = 5'd0;
    ID_UsesRs = 0; ID_UsesRt = 0; EX_MemRead = 0; EX_Rt = 5'd0; EX_BrTaken = 0;
  endtask

  task automatic model_reset();
    m_halt = 0; m_left = -1; m_cyc = 0; m_stall = 0;
  endtask

  // one cycle: check outputs mid-cycle against model, then advance model at the edge
  task automatic step();
    bit lu, jmp, stop;
    int e_pc, e_ifen, e_iff, e_idf, e_sel, e_halt;
    @(negedge CLK);
    lu   = EX_MemRead && EX_Rt != 0 &&
           ((ID_UsesRs && ID_Rs == EX_Rt) || (ID_UsesRt && ID_Rt == EX_Rt));
    jmp  = ID_Opcode == 2 || ID_Opcode == 3 || (ID_Opcode == 0 && ID_Func == 8);
    stop = ID_Opcode == 63;
    e_ifen = -1; e_sel = 0; e_halt = 0;
    if (RESET)              begin e_pc = 0; e_ifen = 0; e_iff = 1; e_idf = 1; end
    else if (m_halt)        begin e_pc = 0; e_ifen = 0; e_iff = 1; e_idf = 1; e_halt = 1; end
    else if (m_left >= 0)   begin e_pc = 0; e_iff = 1; e_idf = 1; end
    else if (EX_BrTaken)    begin e_pc = 1; e_iff = 1; e_idf = 1; e_sel = 1; end
    else if (lu)            begin e_pc = 0; e_ifen = 0; e_iff = 0; e_idf = 1; end
    else if (jmp)           begin e_pc = 1; e_iff = 1; e_idf = 0; e_sel = (ID_Opcode == 0) ? 3 : 2; end
    else if (stop)          begin e_pc = 0; e_iff = 1; e_idf = 1; end
    else                    begin e_pc = 1; e_ifen = 1; e_iff = 0; e_idf = 0; end
    chk("PC_EN", 32'(PC_EN), 32'(e_pc));
    if (e_ifen >= 0) chk("IFID_EN", 32'(IFID_EN), 32'(e_ifen));
    chk("IFID_FLUSH", 32'(IFID_FLUSH), 32'(e_iff));
    chk("IDEX_FLUSH", 32'(IDEX_FLUSH), 32'(e_idf));
    chk("PCSel", 32'(PCSel), 32'(e_sel));
    chk("Halted", 32'(Halted), 32'(e_halt));
    chk("CycleCnt", 32'(CycleCnt), m_cyc);
    chk("StallCnt", 32'(StallCnt), m_stall);
    @(posedge CLK);
    if (RESET) model_reset();
    else if (!m_halt) begin
      if (m_cyc < CMAX) m_cyc++;
      if (m_left >= 0) begin
        if (m_left == 0) begin m_halt = 1; m_left = -1; end
        else m_left--;
      end else if (!EX_BrTaken) begin
        if (lu) begin if (m_stall < CMAX) m_stall++; end
        else if (!jmp && stop) m_left = DRAIN - 1;
      end
    end
    #1;
  endtask

  task automatic rand_in(input bit allow_stop);
    int r;
    RESET = ($urandom_range(0, 99) < 3);
    r = $urandom_range(0, 99);
    ID_Func = ($urandom_range(0, 1) != 0) ? 6'd8 : 6'($urandom_range(0, 63));
    if (r < 30)                   ID_Opcode = 6'd0;
    else if (r < 40)              ID_Opcode = 6'd2;
    else if (r < 45)              ID_Opcode = 6'd3;
    else if (r < 49 && allow_stop) ID_Opcode = 6'd63;
    else                          ID_Opcode = 6'($urandom_range(4, 62));
    ID_Rs = 5'($urandom_range(0, 3));
    ID_Rt = 5'($urandom_range(0, 3));
    ID_UsesRs = 1'($urandom_range(0, 1));
    ID_UsesRt = 1'($urandom_range(0, 1));
    EX_MemRead = ($urandom_range(0, 99) < 40);
    EX_Rt = 5'($urandom_range(0, 3));
    EX_BrTaken = ($urandom_range(0, 99) < 15);
  endtask

  initial begin
    idle();
    RESET = 1;
    @(posedge CLK); #1;
    model_reset();
    step();                        // reset held: forced outputs, counters 0
    // load-use on rs
    idle(); EX_MemRead = 1; EX_Rt = 2; ID_UsesRs = 1; ID_Rs = 2; step();
    idle(); step();
    // LW r0, and rt match that is not used
    idle(); EX_MemRead = 1; EX_Rt = 0; ID_UsesRs = 1; ID_Rs = 0; step();
    idle(); EX_MemRead = 1; EX_Rt = 2; ID_Rt = 2; step();
    // branch beats jump, then plain cycle
    idle(); EX_BrTaken = 1; ID_Opcode = 6'd2; step();
    idle(); step();
    // JR
    idle(); ID_Func = 6'd8; step();
    // STOP then drain to halt
    idle(); ID_Opcode = 6'd63; step();
    idle(); repeat (7) step();
    // reset mid-drain, then full drain again
    idle(); RESET = 1; step();
    idle(); ID_Opcode = 6'd63; step();
    idle(); repeat (2) step();
    RESET = 1; step();
    idle(); ID_Opcode = 6'd63; step();
    idle(); repeat (6) step();
    // random mix
    for (int i = 0; i < 600; i++) begin rand_in(1'b1); step(); end
    // long run without STOP or reset so counters reach saturation
    idle(); RESET = 1; step();
    for (int i = 0; i < 320; i++) begin rand_in(1'b0); RESET = 0; step(); end
    chk("CycleCnt_sat", 32'(CycleCnt), CMAX);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
